// File: rtl/user_ram_pkg.sv
// Shared types and constants for the fabric user-port RAM arbiter.
//   state_t   : arbiter state (INIT until RAM initialisation completes, then RUN)
//   req_id_t  : requester identifier (two requesters -> one bit)
//   NUM_REQ   : number of fabric requesters
//   DEF_*     : default RAM user-port widths
//   STAT_W    : width of the optional statistics counters (USER_RAM_ARB_STATS_EN)
package user_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
    localparam int STAT_W     = 16;

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/user_ram_arbiter_if.sv
// Requester-side bus of the user RAM arbiter.
//   req    : per-requester access request
//   we     : per-requester direction (1 = write, 0 = read)
//   addr   : per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   wdata  : per-requester write data, requester i at [i*DATA_W +: DATA_W]
//   gnt    : combinational accept; transfer on a rising edge with req[i] & gnt[i]
//   rvalid : one-cycle read-data-valid pulse for the requester that issued the read
//   rdata  : read data, meaningful while any rvalid bit is set
// Modports: master = requester side, slave = arbiter side.
interface user_ram_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    import user_ram_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/user_ram_rd_tag_pipe.sv
// Read-tag delay line: carries a valid bit and the owning requester ID
// DEPTH cycles so the tag lines up with the RAM's read data.
//   clk       : clock
//   srst      : synchronous active-high clear (drops every in-flight tag)
//   in_valid  : a read strobe is on the RAM port this cycle
//   in_id     : requester that owns that read
//   out_valid : tag emerging DEPTH cycles later
//   out_id    : owner of the emerging tag
module user_ram_rd_tag_pipe
    import user_ram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    srst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic    valid_reg [DEPTH];
    req_id_t id_reg    [DEPTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i] <= 1'b0;
                id_reg[i]    <= 1'b0;
            end
        end else begin
            valid_reg[0] <= in_valid;
            id_reg[0]    <= in_id;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                id_reg[i]    <= id_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_id    = id_reg[DEPTH-1];

endmodule

// File: rtl/user_ram_arbiter.sv
// Round-robin arbiter sharing the fabric user port of the dual-port RAM
// between two requesters. Traffic is held off until RAM initialisation
// completes and no new grants are issued while the AHB side is busy. Each
// read is tagged so its data returns only to the requester that issued it.
//
// Ports:
//   Clock          : clock, all logic on the rising edge
//   Sclr           : synchronous active-high reset
//   ram_init_done  : RAM initialisation complete
//   ahb_busy       : AHB side busy, blocks new grants
//   rq             : requester bus (user_ram_arbiter_if.slave)
//   wr_enable_user, waddr_user, wdata_user : RAM write port (registered)
//   rd_enable_user, raddr_user             : RAM read port (registered)
//   rdata_user     : RAM read data, RD_LATENCY cycles after rd_enable_user
//   SEL            : a grant was issued this cycle while running and AHB idle
//
// Optional (macro USER_RAM_ARB_STATS_EN):
//   stat_wr, stat_rd : per-requester saturating write/read transfer counts
//   stat_stall       : saturating count of cycles with a request but no grant
//
// RD_LATENCY is legal from 1 to 3.
module user_ram_arbiter
    import user_ram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                Clock,
    input  logic                Sclr,
    input  logic                ram_init_done,
    input  logic                ahb_busy,
    user_ram_arbiter_if.slave   rq,
    output logic                wr_enable_user,
    output logic                rd_enable_user,
    output logic [ADDR_W-1:0]   waddr_user,
    output logic [ADDR_W-1:0]   raddr_user,
    output logic [DATA_W-1:0]   wdata_user,
    input  logic [DATA_W-1:0]   rdata_user,
    output logic                SEL
`ifdef USER_RAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0] stat_wr,
    output logic [NUM_REQ-1:0][STAT_W-1:0] stat_rd,
    output logic [STAT_W-1:0]              stat_stall
`endif
);

    state_t             state_reg, state_next;
    req_id_t            last_gnt_reg;
    logic [NUM_REQ-1:0] gnt_c;
    logic               xfer;
    req_id_t            gnt_id;

    logic               wr_en_reg, rd_en_reg;
    req_id_t            rd_id_reg;
    logic [ADDR_W-1:0]  waddr_reg, raddr_reg;
    logic [DATA_W-1:0]  wdata_reg;

    logic               tag_valid;
    req_id_t            tag_id;

    // Per-requester views of the flat address/data buses.
    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = rq.addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = rq.wdata[gi*DATA_W +: DATA_W];
    end

    // State transition and grant. The grant only ever covers a requesting
    // bit, so any grant bit set is a transfer on the coming edge.
    always_comb begin
        state_next = state_reg;
        gnt_c      = '0;
        case (state_reg)
            INIT: begin
                if (ram_init_done) state_next = RUN;
            end
            RUN: begin
                if (!ram_init_done) begin
                    state_next = INIT;
                end else if (!ahb_busy) begin
                    case (rq.req)
                        2'b01:   gnt_c = 2'b01;
                        2'b10:   gnt_c = 2'b10;
                        // Contention: the requester not served last wins.
                        2'b11:   gnt_c = (last_gnt_reg == 1'b0) ? 2'b10 : 2'b01;
                        default: gnt_c = 2'b00;
                    endcase
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign xfer   = |gnt_c;
    assign gnt_id = gnt_c[1];
    assign SEL    = (state_reg == RUN) && !ahb_busy && xfer;

    always_ff @(posedge Clock) begin
        if (Sclr) begin
            state_reg    <= INIT;
            last_gnt_reg <= 1'b1;
            wr_en_reg    <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_id_reg    <= 1'b0;
            waddr_reg    <= '0;
            raddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= xfer &&  rq.we[gnt_id];
            rd_en_reg <= xfer && !rq.we[gnt_id];
            if (xfer) begin
                last_gnt_reg <= gnt_id;
                if (rq.we[gnt_id]) begin
                    waddr_reg <= addr_arr[gnt_id];
                    wdata_reg <= wdata_arr[gnt_id];
                end else begin
                    raddr_reg <= addr_arr[gnt_id];
                    rd_id_reg <= gnt_id;
                end
            end
        end
    end

    assign wr_enable_user = wr_en_reg;
    assign rd_enable_user = rd_en_reg;
    assign waddr_user     = waddr_reg;
    assign raddr_user     = raddr_reg;
    assign wdata_user     = wdata_reg;
    assign rq.gnt         = gnt_c;

    // The tag enters alongside the read strobe, so after RD_LATENCY stages
    // it meets the RAM's data for that read.
    user_ram_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk       (Clock),
        .srst      (Sclr),
        .in_valid  (rd_en_reg),
        .in_id     (rd_id_reg),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    assign rq.rvalid = {tag_valid && tag_id, tag_valid && !tag_id};
    assign rq.rdata  = tag_valid ? rdata_user : '0;

`ifdef USER_RAM_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        logic [STAT_W-1:0] wr_cnt_reg, rd_cnt_reg;

        always_ff @(posedge Clock) begin
            if (Sclr) begin
                wr_cnt_reg <= '0;
                rd_cnt_reg <= '0;
            end else if (gnt_c[gi]) begin
                if (rq.we[gi]) wr_cnt_reg <= sat_inc(wr_cnt_reg);
                else           rd_cnt_reg <= sat_inc(rd_cnt_reg);
            end
        end

        assign stat_wr[gi] = wr_cnt_reg;
        assign stat_rd[gi] = rd_cnt_reg;
    end

    logic [STAT_W-1:0] stall_cnt_reg;

    always_ff @(posedge Clock) begin
        if (Sclr) begin
            stall_cnt_reg <= '0;
        end else if ((|rq.req) && !xfer) begin
            stall_cnt_reg <= sat_inc(stall_cnt_reg);
        end
    end

    assign stat_stall = stall_cnt_reg;
`endif

endmodule

// File: doc/user_ram_arbiter.md
Name: user_ram_arbiter

Overview:
- Shares the fabric user port of the dual-port RAM (write and read) between two fabric requesters using round-robin arbitration.
- Holds off all traffic until RAM initialisation completes, and pauses new grants while the AHB side is busy.
- Tags each read and returns its data only to the requester that issued it.
- Sits between the fabric requesters (counter/pattern generators and similar user logic) and the RAM user port of the fabric master subsystem.

Parameters:
- ADDR_W, 6, RAM user-port address width.
- DATA_W, 8, RAM user-port data width.
- RD_LATENCY, 1, cycles from rd_enable_user to valid rdata_user (legal values 1..3).

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- Sclr  in  1  synchronous, active-high reset.
- ram_init_done  in  1  RAM initialisation complete.
- ahb_busy  in  1  AHB side busy; no new grants while high.
- req  in  2  per-requester access request.
- we  in  2  per-requester direction: 1 = write, 0 = read.
- addr  in  2*ADDR_W  per-requester address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- wdata  in  2*DATA_W  per-requester write data, sliced the same way.
- gnt  out  2  combinational accept. A transfer occurs on a rising edge where req[i] & gnt[i].
- rvalid  out  2  one-cycle pulse: read data valid for requester i.
- rdata  out  DATA_W  read data, valid when any rvalid bit is set.
- wr_enable_user  out  1  RAM write strobe.
- rd_enable_user  out  1  RAM read strobe.
- waddr_user  out  ADDR_W  RAM write address.
- raddr_user  out  ADDR_W  RAM read address.
- wdata_user  out  DATA_W  RAM write data.
- rdata_user  in  DATA_W  RAM read data.
- SEL  out  1  high when in RUN, ahb_busy is low, and a grant was issued this cycle.

Behaviour:
- Interface fixed: one clock (Clock); reset Sclr is synchronous and active-high.
- **Reset values:** gnt, rvalid, wr_enable_user, rd_enable_user and SEL = 0. All address/data outputs = 0. State = INIT. last_gnt = 1, so requester 0 wins the first contention.
- **INIT state:** gnt = 0. Move to RUN on the first edge where ram_init_done = 1.
- **RUN state:**
  - If ram_init_done falls: return to INIT on the next edge. gnt is forced to 0 in that same cycle (combinational). Reads already in flight still complete.
  - ahb_busy = 1: gnt = 0. In-flight reads still complete.
  - Otherwise: if exactly one requester has req set, grant it. If both do, grant the one that is not last_gnt. last_gnt updates only on a transfer.
  - At most one gnt bit is high in any cycle.
- **Issue timing:**
  - A transfer on edge N drives the RAM strobe for exactly one cycle, N to N+1, with the address/data registered from the granted slice.
  - Write: wr_enable_user = 1, waddr_user and wdata_user set; rd_enable_user = 0.
  - Read: rd_enable_user = 1, raddr_user set.
  - With no transfer, the strobes return to 0 and address/data hold their last value.
- **Read return:**
  - The owner ID and a valid bit travel through a RD_LATENCY-deep shift register.
  - rvalid[owner] pulses together with rdata = rdata_user, RD_LATENCY cycles after the rd_enable_user cycle.
  - Back-to-back reads give back-to-back rvalid pulses, in issue order.
- **Throughput:** one access per cycle. A single continuously requesting requester gets gnt every cycle. Two continuous requesters alternate 0,1,0,1,...
- **Ordering:** a write then a read to the same address from any requesters are issued in grant order. No forwarding is done; read-after-write correctness relies on the RAM.
- **Requester obligations:** hold we/addr/wdata stable while req is high and gnt is low. Dropping req before grant is legal and does not affect fairness.
- **Sclr mid-operation:** the read pipeline is flushed and no rvalid is produced for in-flight reads. The RAM strobe deasserts on the next edge.

Optional Feature:
- Macro: USER_RAM_ARB_STATS_EN.
- **Defined:**
  - Adds output ports stat_wr (2x16) and stat_rd (2x16): per-requester saturating counters of completed write transfers and read transfers.
  - Counters clear on Sclr and stop at 16'hFFFF.
  - Adds output stat_stall (16 bits), saturating, incremented each cycle where some req is high but gnt = 0.
- **Undefined:** ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package user_ram_pkg holds:
  - state enum {INIT, RUN};
  - requester ID type (1 bit);
  - NUM_REQ = 2 constant;
  - default ADDR_W/DATA_W constants;
  - stats counter width 16.
- One sub-module, user_ram_rd_tag_pipe: RD_LATENCY-deep valid+ID shift register with synchronous clear. Instantiated once.

Test Plan:
- **Init hold:** ram_init_done = 0 for 20 cycles, req = 2'b11 → gnt stays 0 and no strobes. Set ram_init_done = 1 → first gnt = 2'b01 two edges later.
- **Contention:** both requesters write continuously for 8 cycles. Requester 0 uses addr 0..7 with data 8'hA0+i; requester 1 uses addr 32..39. → wr_enable_user high all 8 cycles, grants strictly alternate 01,10,..., RAM holds all 8 values with requester 0's addresses 0..3 and requester 1's addresses 32..35 written.
- **Read tagging:** preload addr 5 = 8'h3C and addr 40 = 8'hC3. Requester 0 reads 5, then requester 1 reads 40 in the next cycle. → rvalid = 01 with rdata = 3C, then rvalid = 10 with rdata = C3, at RD_LATENCY = 1 and again at RD_LATENCY = 3.
- **ahb_busy stall:** assert ahb_busy for 4 cycles mid-stream with a read in flight → gnt = 0 and SEL = 0 for those 4 cycles, the in-flight rvalid still arrives, and the stream resumes at the correct round-robin position.
- **Reset mid-read:** Sclr is pulsed one cycle after a rd_enable_user with RD_LATENCY = 2 → no rvalid. All outputs are 0 on the edge after Sclr. State returns to INIT.
- **Stats (with USER_RAM_ARB_STATS_EN):** 3 writes and 2 reads by requester 1, plus 5 stalled cycles → stat_wr[1] = 3, stat_rd[1] = 2, stat_stall = 5.
